// File: rtl/rr_grant_scheduler.sv
// Round-robin single-owner grant scheduler with forced revoke after MAX_HOLD cycles.
// A grant is issued from IDLE, held while GRANT, and released either by the
// owner (i_Release) or by the hold timer. The pointer always moves one past
// the last owner, so every waiting requester is reached within NUM_REQ grants.
module rr_grant_scheduler #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic                       i_Release,
  output logic [NUM_REQ-1:0]         o_Grant,
  output logic [$clog2(NUM_REQ):0]   o_GrantIdx,
  output logic                       o_GrantValid,
  output logic                       o_Timeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int IW = PW + 1;
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [IW:0]    NREQ     = (IW+1)'(NUM_REQ);
  localparam logic [CW-1:0]  HOLD_END = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;

  logic [IW-1:0]        win_idx;
  logic                 win_found;
  logic [IW:0]          scan;

  // Rotating priority scan: first request at or above ptr, wrapping to the bottom.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {2'b00, ptr_q} + (IW+1)'(i);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!win_found && i_Req[scan[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IW-1:0];
      end
    end
  end

  // Next-state: issue, hold, release or force-revoke the grant.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (i_Release || cnt_q == HOLD_END) begin
          state_d   = IDLE;
          grant_d   = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          // A release on the last allowed cycle wins over the timeout.
          timeout_d = !i_Release;
          ptr_d     = (idx_q == LAST_IDX) ? '0 : PW'(idx_q + 1'b1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides any event in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Grant      = grant_q;
  assign o_GrantIdx   = idx_q;
  assign o_GrantValid = valid_q;
  assign o_Timeout    = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios plus random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_rr_grant_scheduler;
  localparam int N  = 8;
  localparam int MH = 16;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic [N-1:0] i_Req = '0;
  logic         i_Release = 1'b0;
  logic [N-1:0] o_Grant;
  logic [3:0]   o_GrantIdx;
  logic         o_GrantValid;
  logic         o_Timeout;

  int n_vec = 0;
  int n_err = 0;

  // model: owner index (-1 = free), cycles the grant has been visible, pointer
  int owner = -1;
  int held  = 0;
  int mptr  = 0;
  bit mto   = 1'b0;

  rr_grant_scheduler #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_Req(i_Req), .i_Release(i_Release),
    .o_Grant(o_Grant), .o_GrantIdx(o_GrantIdx), .o_GrantValid(o_GrantValid),
    .o_Timeout(o_Timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic [N-1:0] req, input logic rel, input logic rstn);
    if (!rstn) begin
      owner = -1; held = 0; mptr = 0; mto = 1'b0;
    end else if (owner < 0) begin
      mto = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && req[(mptr + k) % N]) begin
          owner = (mptr + k) % N;
          held  = 1;
        end
      end
    end else if (rel) begin
      mptr = (owner + 1) % N; owner = -1; mto = 1'b0;
    end else if (held == MH) begin
      mptr = (owner + 1) % N; owner = -1; mto = 1'b1;
    end else begin
      held++; mto = 1'b0;
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic rel, input logic rstn);
    i_Req = req; i_Release = rel; i_rstn = rstn;
    @(posedge i_clk);
    model_edge(req, rel, rstn);
    #1;
    chk("grant",   o_Grant,      (owner >= 0) ? (32'd1 << owner) : 32'd0);
    chk("idx",     o_GrantIdx,   (owner >= 0) ? owner : 0);
    chk("valid",   o_GrantValid, (owner >= 0) ? 1 : 0);
    chk("timeout", o_Timeout,    mto);
    chk("onehot",  ($countones(o_Grant) <= 1) ? 1 : 0, 1);
  endtask

  initial begin
    // reset, then idle with no requests
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 1'b1);
    chk("idle_valid", o_GrantValid, 0);

    // rotating priority from ptr=0
    step(8'h24, 1'b0, 1'b1);
    chk("s33_first", o_GrantIdx, 2);
    step(8'h24, 1'b1, 1'b1);
    chk("s33_gap", o_GrantValid, 0);
    step(8'h24, 1'b0, 1'b1);
    chk("s33_second", o_Grant, 8'h20);
    step(8'h24, 1'b1, 1'b1);
    // wrap-around from ptr=6
    step(8'h01, 1'b0, 1'b1);
    chk("s34_wrap", o_GrantIdx, 0);
    step(8'h00, 1'b1, 1'b1);

    // full rotation with all requesting
    step(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, 1'b1);
      chk("s35_seq", o_GrantIdx, k % N);
      step(8'hFF, 1'b1, 1'b1);
    end

    // timeout on index 3, then regrant of 3 after a full scan
    step(8'h08, 1'b0, 1'b1);
    chk("s36_grant", o_GrantIdx, 3);
    for (int i = 0; i < MH - 1; i++) step(8'h08, 1'b0, 1'b1);
    chk("s36_held", o_GrantValid, 1);
    step(8'h08, 1'b0, 1'b1);
    chk("s36_to", o_Timeout, 1);
    chk("s36_off", o_GrantValid, 0);
    step(8'h08, 1'b0, 1'b1);
    chk("s36_regrant", o_GrantIdx, 3);
    chk("s36_pulse", o_Timeout, 0);

    // release on the last allowed cycle wins over timeout
    for (int i = 0; i < MH - 1; i++) step(8'h08, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    chk("rel_vs_to", o_Timeout, 0);

    // reset in the middle of a grant
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h80, 1'b0, 1'b0);
    chk("s37_rst", o_GrantValid, 0);
    chk("s37_rst_to", o_Timeout, 0);
    step(8'h80, 1'b0, 1'b1);
    chk("s37_idx7", o_GrantIdx, 7);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      logic [N-1:0] r;
      r = N'($urandom) & N'($urandom);
      step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 150) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
